// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package imem_arbiter_pkg;

  localparam int unsigned TAG_W      = 4;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    IF_REQ,
    IF_RSP,
    LS_REQ,
    LS_RSP
  } arb_state_e;

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Saturating count of consecutive load/store grants taken while fetch waits.
module imem_arb_starve_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;

  assign at_max = (cnt_q == CW'(MAX));

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single memory port between fetch and load/store, one
// transaction outstanding, data-priority with bounded fetch starvation.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic [TAG_W-1:0]    i_if_tag,
  input  logic                i_jump,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic [TAG_W-1:0]    o_if_rtag,
  output logic                o_fetch_en,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_be,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  arb_state_e          state_q, state_d;
  logic                drop_q, drop_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                at_max;
  logic                starve_inc, starve_clr;

  // Only the latched bundle reaches memory, and only while requesting.
  assign o_mem_req   = (state_q == IF_REQ) || (state_q == LS_REQ);
  assign o_mem_we    = o_mem_req & we_q;
  assign o_mem_addr  = o_mem_req ? addr_q  : '0;
  assign o_mem_wdata = o_mem_req ? wdata_q : '0;
  assign o_mem_be    = o_mem_req ? be_q    : '0;

  assign starve_inc = o_ls_gnt & i_if_req;
  assign starve_clr = o_if_gnt | ((state_q == IDLE) & ~i_if_req);

  imem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (i_clk),
    .rst    (i_rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

  // Next-state, grants, response pulses and bundle capture.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    tag_d       = tag_q;
    o_if_gnt    = 1'b0;
    o_ls_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_if_rtag   = '0;
    o_fetch_en  = 1'b0;
    o_ls_rvalid = 1'b0;
    o_ls_rdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (i_if_req && (!i_ls_req || at_max)) begin
          o_if_gnt = 1'b1;
          we_d     = 1'b0;
          addr_d   = i_if_addr;
          wdata_d  = '0;
          be_d     = '1;
          tag_d    = i_if_tag;
          drop_d   = i_jump;
          state_d  = IF_REQ;
        end else if (i_ls_req) begin
          o_ls_gnt = 1'b1;
          we_d     = i_ls_we;
          addr_d   = i_ls_addr;
          wdata_d  = i_ls_wdata;
          be_d     = i_ls_be;
          state_d  = LS_REQ;
        end
      end
      IF_REQ: begin
        if (i_jump) drop_d = 1'b1;
        if (i_mem_gnt) state_d = IF_RSP;
      end
      IF_RSP: begin
        if (i_mem_rvalid) begin
          // A jump in the completion cycle also makes this word stale.
          if (!(drop_q || i_jump)) begin
            o_if_rvalid = 1'b1;
            o_fetch_en  = 1'b1;
            o_if_rdata  = i_mem_rdata;
            o_if_rtag   = tag_q;
          end
          drop_d  = 1'b0;
          state_d = IDLE;
        end else if (i_jump) begin
          drop_d = 1'b1;
        end
      end
      LS_REQ: begin
        if (i_mem_gnt) state_d = LS_RSP;
      end
      LS_RSP: begin
        if (i_mem_rvalid) begin
          o_ls_rvalid = 1'b1;
          o_ls_rdata  = we_q ? '0 : i_mem_rdata;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, drop flag and captured request bundle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: table of single transactions plus
// hand-written contention, starvation-clear and mid-transaction reset runs.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, jump, ls_req, ls_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  if_tag, ls_be;
  logic        if_gnt, if_rvalid, fetch_en, ls_gnt, ls_rvalid;
  logic        mem_req, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  if_rtag, mem_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .i_if_tag     (if_tag),
    .i_jump       (jump),
    .o_if_gnt     (if_gnt),
    .o_if_rvalid  (if_rvalid),
    .o_if_rdata   (if_rdata),
    .o_if_rtag    (if_rtag),
    .o_fetch_en   (fetch_en),
    .i_ls_req     (ls_req),
    .i_ls_we      (ls_we),
    .i_ls_addr    (ls_addr),
    .i_ls_wdata   (ls_wdata),
    .i_ls_be      (ls_be),
    .o_ls_gnt     (ls_gnt),
    .o_ls_rvalid  (ls_rvalid),
    .o_ls_rdata   (ls_rdata),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_be     (mem_be),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  // jmp: 0 none, 1 with the grant, 2 first RSP wait cycle, 3 first REQ cycle
  typedef struct {
    logic        ifr;
    logic        lsr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  tag;
    int          gnt_dly;
    int          rsp_wait;
    int          jmp;
    logic [31:0] mrdata;
    logic        e_ifg;
    logic        e_lsg;
    logic        e_ifrv;
    logic        e_lsrv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tagname);
    chk({tagname, " if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tagname, " ls_rvalid"}, {31'd0, ls_rvalid}, 32'd0);
    chk({tagname, " fetch_en"},  {31'd0, fetch_en},  32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("v%0d", idx);
    if_req = v.ifr; ls_req = v.lsr; ls_we = v.we;
    if_addr = v.addr; ls_addr = v.addr; ls_wdata = v.wdata; ls_be = v.be; if_tag = v.tag;
    jump = (v.jmp == 1);
    #1;
    chk({nm, " if_gnt"}, {31'd0, if_gnt}, {31'd0, v.e_ifg});
    chk({nm, " ls_gnt"}, {31'd0, ls_gnt}, {31'd0, v.e_lsg});
    step();
    // Scramble requester inputs to show the bundle was latched.
    if_req = 1'b0; ls_req = 1'b0; jump = 1'b0;
    if_addr = ~v.addr; ls_addr = ~v.addr; ls_wdata = ~v.wdata; ls_be = ~v.be; if_tag = ~v.tag;
    for (int k = 0; k <= v.gnt_dly; k++) begin
      mem_gnt    = (k == v.gnt_dly);
      mem_rvalid = (k != v.gnt_dly);  // stray response while requesting
      mem_rdata  = 32'h5555_AAAA;
      jump       = (v.jmp == 3) && (k == 0);
      #1;
      chk({nm, " mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({nm, " mem_addr"}, mem_addr, v.addr);
      chk({nm, " mem_we"}, {31'd0, mem_we}, {31'd0, v.we & v.lsr});
      if (v.lsr) begin
        chk({nm, " mem_wdata"}, mem_wdata, v.wdata);
        chk({nm, " mem_be"}, {28'd0, mem_be}, {28'd0, v.be});
      end
      chk_quiet({nm, " req"});
      step();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; jump = 1'b0;
    for (int k = 0; k < v.rsp_wait; k++) begin
      jump = (v.jmp == 2) && (k == 0);
      #1;
      chk({nm, " rsp mem_req"}, {31'd0, mem_req}, 32'd0);
      chk_quiet({nm, " wait"});
      step();
    end
    jump = 1'b0; mem_rvalid = 1'b1; mem_rdata = v.mrdata;
    #1;
    chk({nm, " if_rvalid"}, {31'd0, if_rvalid}, {31'd0, v.e_ifrv});
    chk({nm, " fetch_en"}, {31'd0, fetch_en}, {31'd0, v.e_ifrv});
    chk({nm, " ls_rvalid"}, {31'd0, ls_rvalid}, {31'd0, v.e_lsrv});
    if (v.e_ifrv) begin
      chk({nm, " if_rdata"}, if_rdata, v.e_rdata);
      chk({nm, " if_rtag"}, {28'd0, if_rtag}, {28'd0, v.tag});
    end
    if (v.e_lsrv) chk({nm, " ls_rdata"}, ls_rdata, v.e_rdata);
    step();
    mem_rvalid = 1'b0;
  endtask

  // One grant with the currently held requests, then a minimum-latency memory.
  task automatic one_grant(input string nm, input logic exp_if, input logic [31:0] a_if,
                           input logic [31:0] a_ls);
    #1;
    chk({nm, " if_gnt"}, {31'd0, if_gnt}, {31'd0, exp_if});
    chk({nm, " ls_gnt"}, {31'd0, ls_gnt}, {31'd0, ~exp_if});
    step();
    mem_gnt = 1'b1;
    #1;
    chk({nm, " mem_addr"}, mem_addr, exp_if ? a_if : a_ls);
    chk({nm, " no gnt in req"}, {30'd0, if_gnt, ls_gnt}, 32'd0);
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0abc;
    #1;
    chk({nm, " if_rvalid"}, {31'd0, if_rvalid}, {31'd0, exp_if});
    chk({nm, " ls_rvalid"}, {31'd0, ls_rvalid}, {31'd0, ~exp_if});
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    //       ifr   lsr   we    addr          wdata         be     tag    gd rw j  mrdata         ifg   lsg   ifrv  lsrv  e_rdata
    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        4'h0,  4'h5, 0, 0, 0, 32'h0000_0013, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0013};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_1234, 4'h3, 4'h0, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        4'hF,  4'h0, 5, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,        4'h0,  4'h3, 0, 2, 2, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0,        4'h0,  4'hA, 0, 1, 0, 32'h0000_0093, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0093};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        4'h0,  4'h1, 0, 0, 1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0,        4'h0,  4'h2, 2, 0, 3, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0,        4'hF,  4'h0, 0, 1, 2, 32'h3333_3333, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3333_3333};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0304, 32'h0,        4'hF,  4'h0, 0, 0, 1, 32'h4444_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4444_0000};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0048, 32'h0,        4'h0,  4'h7, 1, 1, 0, 32'h4444_4444, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4444_4444};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0,        4'h0,  4'hF, 0, 0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF};

    rst = 1'b1; if_req = 0; jump = 0; ls_req = 0; ls_we = 0; mem_gnt = 0; mem_rvalid = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; mem_rdata = 0; if_tag = 0; ls_be = 0;
    step(); step();
    chk("rst gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst if_rtag", {28'd0, if_rtag}, 32'd0);
    chk("rst ls_rdata", ls_rdata, 32'd0);
    chk_quiet("rst");
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

    // Sustained contention: four LS grants, then fetch is forced, repeating.
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    if_addr = 32'h0000_0600; ls_addr = 32'h0000_0500; if_tag = 4'h1;
    for (int g = 0; g < 10; g++)
      one_grant($sformatf("cont%0d", g), (g == 4) || (g == 9), 32'h600, 32'h500);

    // An IDLE cycle without a fetch request restarts the starvation count.
    one_grant("pre0", 1'b0, 32'h600, 32'h500);
    one_grant("pre1", 1'b0, 32'h600, 32'h500);
    if_req = 1'b0; ls_req = 1'b0;
    step();
    if_req = 1'b1; ls_req = 1'b1;
    for (int g = 0; g < 5; g++)
      one_grant($sformatf("clr%0d", g), (g == 4), 32'h600, 32'h500);
    if_req = 1'b0; ls_req = 1'b0;
    step();

    // Reset while waiting in IF_RSP, then a stale response after release.
    if_req = 1'b1; if_addr = 32'h0000_0700; if_tag = 4'h6;
    #1;
    chk("rr if_gnt", {31'd0, if_gnt}, 32'd1);
    step();
    if_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rr mem_req", {31'd0, mem_req}, 32'd0);
    chk("rr mem_addr", mem_addr, 32'd0);
    chk_quiet("rr in reset");
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    if_req = 1'b1; if_addr = 32'h0000_0704; if_tag = 4'h9;
    #1;
    chk_quiet("rr stale");
    chk("rr idle if_gnt", {31'd0, if_gnt}, 32'd1);
    step();
    mem_rvalid = 1'b0; if_req = 1'b0; mem_gnt = 1'b1;
    #1;
    chk("rr2 mem_addr", mem_addr, 32'h0000_0704);
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
    #1;
    chk("rr2 if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("rr2 fetch_en", {31'd0, fetch_en}, 32'd1);
    chk("rr2 if_rdata", if_rdata, 32'h0000_0077);
    chk("rr2 if_rtag", {28'd0, if_rtag}, 32'd9);
    step();
    mem_rvalid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
